// File: rtl/mbx_pkg.sv
// Shared types and widths for the byte-mailbox drain path.
package mbx_pkg;

  localparam int unsigned MBX_DATA_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } pack_state_e;

  typedef logic [7:0] mbx_byte_t;

endpackage

// File: rtl/mbx_word_packer.sv
// Drains the byte mailbox and packs bytes little-endian into words on a valid/ready port.
// Optional even parity output enabled by defining MBX_PACK_PARITY_EN.
module mbx_word_packer
  import mbx_pkg::*;
#(
  parameter int unsigned DATA_W         = MBX_DATA_W,
  parameter int unsigned BYTES_PER_WORD = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    mbx_empty,
  output logic                                    mbx_rd_en,
  input  logic [DATA_W-1:0]                       mbx_data,
  input  logic                                    flush,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_W*BYTES_PER_WORD-1:0]        out_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]     out_nbytes
`ifdef MBX_PACK_PARITY_EN
  ,
  output logic                                    out_parity
`endif
);

  localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD + 1);
  localparam int unsigned WORD_W = DATA_W * BYTES_PER_WORD;

  pack_state_e       r_state;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  r_captured;
  logic              r_rd_pend;
  logic              r_flush_pend;
  logic [WORD_W-1:0] r_word;

  logic              w_rd_en;
  logic              w_capture;
  logic              w_full;
  logic              w_flush_emit;
  logic              w_flush_drop;
  logic              w_accept;
  logic [WORD_W-1:0] w_word_cap;

  // Pop request is combinational on the mailbox empty flag so pops can run back-to-back.
  assign w_rd_en = rst_n && (r_state == FILL) && !mbx_empty &&
                   (r_issued < CNT_W'(BYTES_PER_WORD)) && !r_flush_pend;
  assign mbx_rd_en = w_rd_en;

  assign w_capture    = (r_state == FILL) && r_rd_pend && (r_captured < CNT_W'(BYTES_PER_WORD));
  assign w_full       = w_capture && (r_captured == CNT_W'(BYTES_PER_WORD - 1));
  assign w_flush_emit = (r_state == FILL) && r_flush_pend && !r_rd_pend && (r_captured != '0);
  assign w_flush_drop = (r_state == FILL) && r_flush_pend && !r_rd_pend && (r_captured == '0);
  assign w_accept     = out_valid && out_ready;

  // Word image including the byte landing this cycle, so a full word can be emitted on the same edge.
  always_comb begin
    w_word_cap = r_word;
    if (w_capture) begin
      w_word_cap[int'(r_captured) * DATA_W +: DATA_W] = mbx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_issued     <= '0;
      r_captured   <= '0;
      r_rd_pend    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_word       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_nbytes   <= '0;
`ifdef MBX_PACK_PARITY_EN
      out_parity   <= 1'b0;
`endif
    end else begin
      r_rd_pend <= w_rd_en;
      if (w_rd_en && (r_issued < CNT_W'(BYTES_PER_WORD))) begin
        r_issued <= r_issued + CNT_W'(1);
      end

      case (r_state)
        FILL: begin
          r_flush_pend <= flush || (r_flush_pend && !(w_flush_emit || w_flush_drop));
          if (w_capture) begin
            r_word     <= w_word_cap;
            r_captured <= r_captured + CNT_W'(1);
          end
          if (w_full) begin
            r_state    <= OUT;
            out_valid  <= 1'b1;
            out_data   <= w_word_cap;
            out_nbytes <= CNT_W'(BYTES_PER_WORD);
`ifdef MBX_PACK_PARITY_EN
            out_parity <= ^w_word_cap;
`endif
          end else if (w_flush_emit) begin
            // Unfilled lanes are already zero: lanes are cleared on every accept and on reset.
            r_state    <= OUT;
            out_valid  <= 1'b1;
            out_data   <= r_word;
            out_nbytes <= r_captured;
`ifdef MBX_PACK_PARITY_EN
            out_parity <= ^r_word;
`endif
          end
        end
        OUT: begin
          r_flush_pend <= r_flush_pend || flush;
          if (w_accept) begin
            r_state    <= FILL;
            out_valid  <= 1'b0;
            r_issued   <= '0;
            r_captured <= '0;
            r_word     <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mbx_word_packer.sv
// Randomized bench for mbx_word_packer: queue-based mailbox and word-grouping reference model.
module tb_mbx_word_packer;

  localparam int BPW = 4;
  localparam int W   = 8 * BPW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mbx_empty;
  logic         mbx_rd_en;
  logic [7:0]   mbx_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_nbytes;
`ifdef MBX_PACK_PARITY_EN
  logic         out_parity;
`endif

  mbx_word_packer #(.DATA_W(8), .BYTES_PER_WORD(BPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mbx_empty  (mbx_empty),
    .mbx_rd_en  (mbx_rd_en),
    .mbx_data   (mbx_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nbytes (out_nbytes)
`ifdef MBX_PACK_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]   mb_q[$];
  logic [7:0]   pend[$];
  logic [W-1:0] exp_data[$];
  int           exp_nb[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_pops = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  bit prev_hold = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: popped bytes accumulate; a full group or a flush closes a word.
  task automatic model_emit();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < pend.size(); i++) w[i*8 +: 8] = pend[i];
    exp_data.push_back(w);
    exp_nb.push_back(pend.size());
    pend.delete();
  endtask

  task automatic model_pop(input logic [7:0] b);
    pend.push_back(b);
    if (pend.size() == BPW) model_emit();
  endtask

  task automatic model_flush();
    if (pend.size() > 0) model_emit();
  endtask

  task automatic push(input logic [7:0] b);
    mb_q.push_back(b);
    mbx_empty = 1'b0;
  endtask

  task automatic tick();
    logic [7:0] b;
    bit         got;
    got = 1'b0;
    b   = 8'h00;
    @(posedge clk);
    cyc++;
    if (rst_n && mbx_rd_en) begin
      if (mb_q.size() > 0) b = mb_q.pop_front();
      if (n_pops == 0) first_pop_cyc = cyc - 1;
      last_pop_cyc = cyc - 1;
      n_pops++;
      got = 1'b1;
      model_pop(b);
    end
    if (rst_n && flush) model_flush();
    #1;
    if (got) mbx_data = b;
    flush     = 1'b0;
    mbx_empty = (mb_q.size() == 0);
  endtask

  task automatic wait_valid(input string name, input int bound);
    int i;
    i = 0;
    while (!out_valid && i < bound) begin
      tick();
      i++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: out_valid still %0b after %0d cycles, expected 1", name, out_valid, bound);
    end
  endtask

  task automatic drain(input string name, input int bound);
    int i;
    i = 0;
    while ((out_valid || exp_data.size() != 0) && i < bound) begin
      tick();
      i++;
    end
    check({name, "_drained"}, W'(exp_data.size()), W'(0));
  endtask

  // Output checker: every valid cycle must present the oldest expected word unchanged.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      check("rd_en_while_valid", W'(mbx_rd_en & out_valid), W'(0));
      check("rd_en_while_empty", W'(mbx_rd_en & mbx_empty), W'(0));
      if (prev_hold) check("valid_dropped", W'(out_valid), W'(1));
      if (out_valid) begin
        if (exp_data.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h with no word expected (cycle %0d)", out_data, cyc);
        end else begin
          check("word_data", out_data, exp_data[0]);
          check("word_nbytes", W'(out_nbytes), W'(exp_nb[0]));
`ifdef MBX_PACK_PARITY_EN
          check("word_parity", W'(out_parity), W'(^exp_data[0]));
`endif
          if (out_ready) begin
            void'(exp_data.pop_front());
            void'(exp_nb.pop_front());
          end
        end
      end
      prev_hold = out_valid && !out_ready;
    end
  end

  initial begin
    int pops_before;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    mbx_data  = 8'h00;
    mbx_empty = 1'b1;

    // Reset with a non-empty mailbox: no pops, outputs cleared.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) tick();
    check("rst_rd_en", W'(mbx_rd_en), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_out_nbytes", W'(out_nbytes), W'(0));
`ifdef MBX_PACK_PARITY_EN
    check("rst_out_parity", W'(out_parity), W'(0));
`endif

    // Full word with latency.
    n_pops = 0;
    rst_n  = 1'b1;
    wait_valid("full", 20);
    check("full_latency", W'(cyc - first_pop_cyc), W'(BPW + 1));
    check("full_pops", W'(n_pops), W'(4));
    check("full_pop_span", W'(last_pop_cyc - first_pop_cyc), W'(3));
    check("full_data", out_data, 32'h44332211);
    check("full_nbytes", W'(out_nbytes), W'(4));
    check("full_model", exp_data[0], 32'h44332211);
    drain("full", 20);

    // Backpressure.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid("bp1", 20);
    check("bp1_model", exp_data[0], 32'h04030201);
    pops_before = n_pops;
    repeat (10) tick();
    check("bp_hold_valid", W'(out_valid), W'(1));
    check("bp_hold_data", out_data, 32'h04030201);
    check("bp_no_pops", W'(n_pops - pops_before), W'(0));
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_resume_pop", W'(n_pops - pops_before), W'(1));
    wait_valid("bp2", 20);
    check("bp2_data", out_data, 32'h08070605);
    drain("bp", 20);

    // Flush of a partial word.
    push(8'hAA); push(8'hBB);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    wait_valid("flush", 10);
    check("flush_data", out_data, 32'h0000BBAA);
    check("flush_nbytes", W'(out_nbytes), W'(2));
    check("flush_model", W'(exp_nb[0]), W'(2));
    drain("flush", 20);

    // Flush in the cycle of the third pop.
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    tick();
    tick();
    flush = 1'b1;
    tick();
    wait_valid("flush_inflight", 10);
    check("flush_inflight_data", out_data, 32'h00CCBBAA);
    check("flush_inflight_nbytes", W'(out_nbytes), W'(3));
    drain("flush_inflight", 20);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    drain("flush_tail", 20);

    // Reset in the middle of a word.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) tick();
    rst_n = 1'b0;
    mb_q.delete();
    pend.delete();
    exp_data.delete();
    exp_nb.delete();
    mbx_empty = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
    wait_valid("midrst", 20);
    check("midrst_data", out_data, 32'h8D7C6B5A);
`ifdef MBX_PACK_PARITY_EN
    check("midrst_parity", W'(out_parity), W'(0));
`endif
    drain("midrst", 20);

    // Random traffic: pushes into an 8-deep mailbox, random backpressure and flushes.
    for (int i = 0; i < 3000; i++) begin
      if (mb_q.size() < 8 && $urandom_range(0, 99) < 60) push(8'($urandom));
      out_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 99) < 4);
      tick();
    end
    out_ready = 1'b1;
    repeat (30) tick();
    flush = 1'b1;
    tick();
    drain("random", 100);
    check("random_pend_empty", W'(pend.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
